// File: rtl/player_motion_ctrl_pkg.sv
// Shared definitions for the player motion controller and the renderer top.
// Holds the default screen geometry, the FSM state encodings and the datapath widths.
package player_motion_ctrl_pkg;

    // Default screen geometry and box placement, shared with the renderer top.
    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int BOX_WIDTH_DEF = 30;
    localparam int START_X_DEF   = 305;
    localparam int MAX_SPEED_DEF = 4;

    // Datapath widths: 10-bit screen coordinates, 4-bit speed (covers 1..15),
    // 11-bit signed intermediate so that x +/- speed can never overflow.
    localparam int X_W   = 10;
    localparam int Y_W   = 10;
    localparam int SPD_W = 4;
    localparam int NX_W  = X_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE_L = 2'd1,
        ST_MOVE_R = 2'd2
    } state_t;

    // Requested direction from the synchronised buttons; none or both means stop.
    function automatic state_t decode_request(input logic l_s, input logic r_s);
        state_t req;
        req = ST_IDLE;
        if (l_s && !r_s) begin
            req = ST_MOVE_L;
        end else if (r_s && !l_s) begin
            req = ST_MOVE_R;
        end
        return req;
    endfunction

endpackage

// File: rtl/player_motion_ctrl_btn_sync.sv
// Button synchronizer (btn_sync): two flops per bit bring the asynchronous
// board buttons into the clk domain. Output is valid two cycles after a pin change.
module player_motion_ctrl_btn_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    // Two-stage synchronizer chain, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    assign dout = sync_p1;

endmodule

// File: rtl/player_motion_ctrl.sv
// Player motion controller: owns the player box X position used by the renderer.
// Buttons are synchronised, a one-cycle frame_tick marks vblank entry, and on each
// tick the IDLE/MOVE_L/MOVE_R FSM ramps speed and moves player_x.
// Build option: define PLAYER_WRAP_EN to make the box wrap around the screen edges
// instead of clamping at 0 and MAX_X.
module player_motion_ctrl
    import player_motion_ctrl_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int BOX_WIDTH = BOX_WIDTH_DEF,
    parameter int START_X   = START_X_DEF,
    parameter int MAX_SPEED = MAX_SPEED_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic [Y_W-1:0] y,
    output logic [X_W-1:0] player_x,
    output logic           frame_tick,
    output logic           moving
);

    localparam int                      MAX_X      = H_ACTIVE - BOX_WIDTH;
    localparam logic signed [NX_W-1:0]  MAX_X_S    = NX_W'(MAX_X);
    localparam logic signed [NX_W-1:0]  SPAN_S     = NX_W'(MAX_X + 1);
    localparam logic [SPD_W-1:0]        MAX_SPD_U  = SPD_W'(MAX_SPEED);
    localparam logic [X_W-1:0]          START_X_U  = X_W'(START_X);
    localparam logic [Y_W-1:0]          V_ACTIVE_U = Y_W'(V_ACTIVE);

    // Bring an out-of-range candidate position back onto the screen:
    // wrap-around when PLAYER_WRAP_EN is defined, saturate otherwise.
    function automatic logic [X_W-1:0] fix_edge(input logic signed [NX_W-1:0] nx);
        logic signed [NX_W-1:0] adj;
        adj = nx;
`ifdef PLAYER_WRAP_EN
        if (nx > MAX_X_S) begin
            adj = nx - SPAN_S;
        end else if (nx < 0) begin
            adj = nx + SPAN_S;
        end
`else
        if (nx > MAX_X_S) begin
            adj = MAX_X_S;
        end else if (nx < 0) begin
            adj = '0;
        end
`endif
        return adj[X_W-1:0];
    endfunction

    // Next speed on a tick: stop when idle, restart at 1 on a direction change,
    // otherwise ramp by one up to MAX_SPEED.
    function automatic logic [SPD_W-1:0] next_speed(input state_t cur, input state_t nxt,
                                                    input logic [SPD_W-1:0] spd);
        logic [SPD_W-1:0] res;
        if (nxt == ST_IDLE) begin
            res = '0;
        end else if (nxt != cur) begin
            res = SPD_W'(1);
        end else if (spd < MAX_SPD_U) begin
            res = spd + SPD_W'(1);
        end else begin
            res = MAX_SPD_U;
        end
        return res;
    endfunction

    logic [1:0]              btn_s;
    logic                    l_s;
    logic                    r_s;
    logic                    vblank;
    logic                    vblank_q;
    logic                    tick;
    state_t                  state_q;
    state_t                  state_d;
    logic [SPD_W-1:0]        speed_q;
    logic [SPD_W-1:0]        speed_d;
    logic [X_W-1:0]          x_q;
    logic [X_W-1:0]          x_d;
    logic signed [NX_W-1:0]  nx;
    logic signed [NX_W-1:0]  step;

    player_motion_ctrl_btn_sync #(
        .WIDTH (2)
    ) u_btn_sync (
        .clk  (clk),
        .rst  (rst),
        .din  ({btn_left, btn_right}),
        .dout (btn_s)
    );

    assign l_s = btn_s[1];
    assign r_s = btn_s[0];

    // vblank entry detector. vblank_q resets high so that releasing reset inside
    // vblank does not produce a spurious tick; the tick is masked while in reset.
    assign vblank = (y >= V_ACTIVE_U);
    assign tick   = vblank & ~vblank_q & rst;

    // Delayed vblank flag for the edge detector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vblank_q <= 1'b1;
        end else begin
            vblank_q <= vblank;
        end
    end

    // Next-state, speed and position; everything holds except on a tick.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        x_d     = x_q;
        nx      = $signed({1'b0, x_q});
        step    = '0;
        if (tick) begin
            state_d = decode_request(l_s, r_s);
            speed_d = next_speed(state_q, state_d, speed_q);
            step    = $signed({{(NX_W-SPD_W){1'b0}}, speed_d});
            case (state_d)
                ST_MOVE_L: nx = $signed({1'b0, x_q}) - step;
                ST_MOVE_R: nx = $signed({1'b0, x_q}) + step;
                default:   nx = $signed({1'b0, x_q});
            endcase
            x_d = fix_edge(nx);
        end
    end

    // FSM state, speed and position registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            speed_q <= '0;
            x_q     <= START_X_U;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            x_q     <= x_d;
        end
    end

    assign player_x   = x_q;
    assign frame_tick = tick;
    assign moving     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Testbench for player_motion_ctrl: randomized and directed button/frame stimulus,
// an abstract reference model of the motion rules, and a queue-based scoreboard
// whose monitor compares player_x/moving on the cycle after every frame_tick.
module tb_player_motion_ctrl;

    localparam int START_X   = 305;
    localparam int MAX_X     = 610;
    localparam int MAX_SPEED = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic [9:0] y = 10'd100;
    logic [9:0] player_x;
    logic       frame_tick;
    logic       moving;

    int total = 0;
    int bad   = 0;
    int ticks = 0;

    typedef struct {
        int x;
        int mv;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: position, last direction (-1/0/+1), speed.
    int m_x;
    int m_dir;
    int m_spd;

    player_motion_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .y          (y),
        .player_x   (player_x),
        .frame_tick (frame_tick),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_x   = START_X;
        m_dir = 0;
        m_spd = 0;
    endfunction

    // One frame of the motion rules, expected result queued for the monitor.
    function automatic void model_frame(input bit l, input bit r);
        int d;
        exp_t e;
        d = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
        if (d == 0) m_spd = 0;
        else if (d == m_dir) m_spd = (m_spd + 1 > MAX_SPEED) ? MAX_SPEED : m_spd + 1;
        else m_spd = 1;
        m_dir = d;
        m_x = m_x + d * m_spd;
`ifdef PLAYER_WRAP_EN
        if (m_x > MAX_X) m_x = m_x - (MAX_X + 1);
        else if (m_x < 0) m_x = m_x + (MAX_X + 1);
`else
        if (m_x > MAX_X) m_x = MAX_X;
        else if (m_x < 0) m_x = 0;
`endif
        e.x  = m_x;
        e.mv = (d != 0) ? 1 : 0;
        exp_q.push_back(e);
    endfunction

    // Hold buttons long enough to pass the synchronizer, then make y cross 479->480.
    task automatic frame(input bit l, input bit r);
        @(posedge clk); #1;
        btn_left  = l;
        btn_right = r;
        y = 10'd100;
        repeat (4) @(posedge clk);
        #1 y = 10'd479;
        @(posedge clk); #1;
        model_frame(l, r);
        y = 10'd480;
        repeat (2) @(posedge clk);
        #1 y = 10'd100;
    endtask

    // Monitor: every tick pops one expectation and checks the following cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                ticks++;
                if (rst !== 1'b1) begin
                    total++;
                    bad++;
                    $display("FAIL tick_in_reset: got frame_tick=1 expected 0 at %0t", $time);
                end else if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tick: got frame_tick=1 expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    check("player_x", int'(player_x), e.x);
                    check("moving", int'(moving), e.mv);
                end
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int sel;
        int t0;

        // Reset with y in active video.
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_player_x", int'(player_x), START_X);
        check("reset_moving", int'(moving), 0);
        check("reset_frame_tick", int'(frame_tick), 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // One vblank entry gives exactly one tick.
        frame(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        check("single_tick_count", ticks, 1);

        // Ramp right: 1,2,3 -> 311, then ten frames total -> 339.
        repeat (3) frame(1'b0, 1'b1);
        @(negedge clk);
        check("ramp3_player_x", int'(player_x), 311);
        repeat (7) frame(1'b0, 1'b1);
        @(negedge clk);
        check("ramp10_player_x", int'(player_x), 339);

        // Run into the right edge and keep pushing.
        repeat (160) frame(1'b0, 1'b1);
`ifndef PLAYER_WRAP_EN
        @(negedge clk);
        check("clamp_right", int'(player_x), MAX_X);
`endif
        // Both buttons stop and freeze, then left restarts at speed 1.
        repeat (2) frame(1'b1, 1'b1);
        @(negedge clk);
        check("both_moving", int'(moving), 0);
        frame(1'b1, 1'b0);
        // Run into the left edge and keep pushing.
        repeat (170) frame(1'b1, 1'b0);
`ifndef PLAYER_WRAP_EN
        @(negedge clk);
        check("clamp_left", int'(player_x), 0);
`endif

        // Randomized runs of button patterns.
        n = 0;
        while (n < 200) begin
            int run;
            sel = $urandom_range(0, 3);
            run = $urandom_range(1, 8);
            for (int i = 0; i < run; i++) begin
                frame(sel == 1, sel >= 2 ? (sel == 2 || sel == 3) : 1'b0);
            end
            n = n + run;
        end

        // Reset asserted and released inside vblank: no tick until the next entry.
        frame(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1 y = 10'd480;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        t0 = ticks;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("vblank_release_ticks", ticks, t0);
        check("vblank_release_player_x", int'(player_x), START_X);
        frame(1'b0, 1'b1);
        repeat (3) @(posedge clk);
        check("post_reset_tick_count", ticks, t0 + 1);
        check("post_reset_player_x", int'(player_x), START_X + 1);

        repeat (5) @(posedge clk);
        check("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
